// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the program loader.
package mem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);
    localparam int DEF_ADDR_W     = 7;
    localparam int DEF_DATA_W     = 32;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        WRITE,
        VERIFY,
        DONE
    } state_t;

    // Requested word count limited to what the Memory can hold.
    function automatic logic [7:0] clamp_count(input logic [7:0] n, input int max_words);
        return (int'(n) > max_words) ? 8'(max_words) : n;
    endfunction

endpackage

// File: rtl/mem_loader_if.sv
// Loader bus bundle: byte-stream handshake plus Memory CS/WE/ADDR control.
interface mem_loader_if #(
    parameter int ADDR_W = mem_loader_pkg::DEF_ADDR_W
) ();

    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              CS;
    logic              WE;
    logic [ADDR_W-1:0] ADDR;

    modport master (
        input  byte_in,
        input  byte_valid,
        output byte_ready,
        output CS,
        output WE,
        output ADDR
    );

    modport slave (
        output byte_in,
        output byte_valid,
        input  byte_ready,
        input  CS,
        input  WE,
        input  ADDR
    );

endinterface

// File: rtl/mem_loader_byte_packer.sv
// Big-endian byte-to-word assembler: first accepted byte lands in the top lane.
module byte_packer
    import mem_loader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              accept,
    input  logic              clear,
    input  logic [7:0]        byte_in,
    output logic [DATA_W-1:0] word,
    output logic              word_full
);

    logic [LANE_W-1:0] lane;

    // High on the accept that completes a word, so the FSM can leave COLLECT on that edge.
    assign word_full = accept && (lane == LANE_W'(BYTES_PER_WORD - 1));

    // NOTE: clocked state is assigned with <= only, so every block sees pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST || clear) begin
            lane <= '0;
        end else if (word_full) begin
            lane <= '0;
        end else if (accept) begin
            lane <= lane + LANE_W'(1);
        end
    end

    // NOTE: the word register is pure datapath and left unreset; four shifts fully overwrite it.
    always_ff @(posedge CLK) begin
        if (accept) begin
            word <= {word[DATA_W-9:0], byte_in};
        end
    end

endmodule

// File: rtl/mem_loader.sv
// Program loader: streams bytes into big-endian words and writes them to consecutive
// Memory addresses while holding the CPU off the bus. LOADER_VERIFY_EN adds read-back verify.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = 128
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [7:0]        num_words,
    mem_loader_if.master      lif,
    inout  wire  [DATA_W-1:0] Mem_Bus,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic [7:0]        words_loaded,
    output logic              verify_err
);

    state_t            state;
    logic [7:0]        target;
    logic              bus_oe;
    logic              accept;
    logic              clear;
    logic              word_full;
    logic [DATA_W-1:0] word;
    logic              last_word;
    logic [ADDR_W-1:0] word_addr;

    assign accept    = lif.byte_valid & lif.byte_ready;
    assign clear     = (state == IDLE) & start;
    assign last_word = (words_loaded + 8'd1) == target;
    // Address arithmetic wraps naturally at 2^ADDR_W.
    assign word_addr = ADDR_W'(BASE_ADDR + int'(words_loaded));
    assign Mem_Bus   = bus_oe ? word : {DATA_W{1'bz}};

    byte_packer #(
        .DATA_W(DATA_W)
    ) u_packer (
        .CLK      (CLK),
        .RST      (RST),
        .accept   (accept),
        .clear    (clear),
        .byte_in  (lif.byte_in),
        .word     (word),
        .word_full(word_full)
    );

`ifdef LOADER_VERIFY_EN
    logic verr;
    assign verify_err = verr;
`else
    assign verify_err = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state          <= IDLE;
            target         <= '0;
            words_loaded   <= '0;
            lif.byte_ready <= 1'b0;
            lif.CS         <= 1'b0;
            lif.WE         <= 1'b0;
            lif.ADDR       <= '0;
            bus_oe         <= 1'b0;
            cpu_hold       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
`ifdef LOADER_VERIFY_EN
            verr           <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        target       <= clamp_count(num_words, MAX_WORDS);
                        words_loaded <= '0;
                        busy         <= 1'b1;
`ifdef LOADER_VERIFY_EN
                        verr         <= 1'b0;
`endif
                        if (clamp_count(num_words, MAX_WORDS) == 8'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state          <= COLLECT;
                            lif.byte_ready <= 1'b1;
                            cpu_hold       <= 1'b1;
                        end
                    end
                end

                COLLECT: begin
                    if (word_full) begin
                        state          <= WRITE;
                        lif.byte_ready <= 1'b0;
                        lif.CS         <= 1'b1;
                        lif.WE         <= 1'b1;
                        lif.ADDR       <= word_addr;
                        bus_oe         <= 1'b1;
                    end
                end

                WRITE: begin
                    lif.WE <= 1'b0;
                    bus_oe <= 1'b0;
`ifdef LOADER_VERIFY_EN
                    // CS stays high: the next cycle is a read of the same address.
                    state  <= VERIFY;
`else
                    lif.CS       <= 1'b0;
                    words_loaded <= words_loaded + 8'd1;
                    if (last_word) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else begin
                        state          <= COLLECT;
                        lif.byte_ready <= 1'b1;
                    end
`endif
                end

`ifdef LOADER_VERIFY_EN
                VERIFY: begin
                    if (Mem_Bus != word) begin
                        verr <= 1'b1;
                    end
                    lif.CS       <= 1'b0;
                    words_loaded <= words_loaded + 8'd1;
                    if (last_word) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else begin
                        state          <= COLLECT;
                        lif.byte_ready <= 1'b1;
                    end
                end
`endif

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: two instances (base 0 and base 120) with Memory models.
`timescale 1ns/1ps
module tb_mem_loader;
    import mem_loader_pkg::*;

`ifdef LOADER_VERIFY_EN
    localparam int CPW = 6;
`else
    localparam int CPW = 5;
`endif
    localparam int BUDGET = 2000;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       start0 = 1'b0;
    logic       start1 = 1'b0;
    logic [7:0] num_words = 8'd0;
    logic [7:0] byte_in = 8'd0;
    logic       byte_valid = 1'b0;
    bit         sel = 1'b0;
    bit         corrupt = 1'b0;

    wire  [31:0] mem_bus0;
    wire  [31:0] mem_bus1;
    logic        hold0, busy0, done0, verr0;
    logic        hold1, busy1, done1, verr1;
    logic [7:0]  wl0, wl1;

    int n_vec = 0;
    int n_err = 0;
    int writes0 = 0;
    int writes1 = 0;
    int cs0 = 0;

    logic [31:0] ram0 [128];
    logic [31:0] ram1 [128];
    logic        rd_en0 = 1'b0;
    logic        rd_en1 = 1'b0;
    logic [31:0] rd_dat0 = '0;
    logic [31:0] rd_dat1 = '0;

    mem_loader_if #(.ADDR_W(7)) lif0 ();
    mem_loader_if #(.ADDR_W(7)) lif1 ();

    assign lif0.byte_in    = byte_in;
    assign lif0.byte_valid = byte_valid & ~sel;
    assign lif1.byte_in    = byte_in;
    assign lif1.byte_valid = byte_valid & sel;

    mem_loader #(.ADDR_W(7), .DATA_W(32), .BASE_ADDR(0), .MAX_WORDS(128)) dut (
        .CLK(CLK), .RST(RST), .start(start0), .num_words(num_words), .lif(lif0),
        .Mem_Bus(mem_bus0), .cpu_hold(hold0), .busy(busy0), .done(done0),
        .words_loaded(wl0), .verify_err(verr0)
    );

    mem_loader #(.ADDR_W(7), .DATA_W(32), .BASE_ADDR(120), .MAX_WORDS(128)) dut_w (
        .CLK(CLK), .RST(RST), .start(start1), .num_words(num_words), .lif(lif1),
        .Mem_Bus(mem_bus1), .cpu_hold(hold1), .busy(busy1), .done(done1),
        .words_loaded(wl1), .verify_err(verr1)
    );

    always #5 CLK = ~CLK;

    // Memory models: write and read latch on negedge; read data driven until the next negedge.
    always @(negedge CLK) begin
        rd_en0 <= 1'b0;
        if (lif0.CS) cs0 <= cs0 + 1;
        if (lif0.CS && lif0.WE) begin
            ram0[lif0.ADDR] <= mem_bus0;
            writes0 <= writes0 + 1;
        end else if (lif0.CS) begin
            rd_en0  <= 1'b1;
            rd_dat0 <= ram0[lif0.ADDR] ^ ((corrupt && lif0.ADDR == 7'd0) ? 32'h0000_00FF : 32'h0);
        end
    end
    assign mem_bus0 = rd_en0 ? rd_dat0 : 32'hzzzz_zzzz;

    always @(negedge CLK) begin
        rd_en1 <= 1'b0;
        if (lif1.CS && lif1.WE) begin
            ram1[lif1.ADDR] <= mem_bus1;
            writes1 <= writes1 + 1;
        end else if (lif1.CS) begin
            rd_en1  <= 1'b1;
            rd_dat1 <= ram1[lif1.ADDR];
        end
    end
    assign mem_bus1 = rd_en1 ? rd_dat1 : 32'hzzzz_zzzz;

    logic [21:0] outs0;
    assign outs0 = {lif0.byte_ready, lif0.CS, lif0.WE, lif0.ADDR, hold0, busy0, done0, wl0, verr0};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] byte_at(input int mode, input int j);
        logic [9:0] jj;
        jj = 10'(j);
        case (mode)
            0: case (j % 8)
                   0: return 8'h12;
                   1: return 8'h34;
                   2: return 8'h56;
                   3: return 8'h78;
                   4: return 8'hAB;
                   5: return 8'hCD;
                   6: return 8'hEF;
                   default: return 8'h01;
               endcase
            1: return jj[7:0] ^ {jj[9:8], 6'b0};
            default: return 8'hC0 + jj[7:0];
        endcase
    endfunction

    // Drives one load; returns cycles from the start cycle to the done pulse (-1 if none).
    task automatic run_load(input bit s, input logic [7:0] n, input int mode, input bit gaps,
                            input bit restart, input int rst_at,
                            output int cycles, output logic hold_first, output logic ve_first);
        int ptr = 0;
        int cyc = 0;
        bit xfer = 1'b0;
        bit stop = 1'b0;
        cycles = -1;
        hold_first = 1'b0;
        ve_first = 1'b0;
        sel = s;
        @(negedge CLK);
        num_words = n;
        if (s) start1 = 1'b1; else start0 = 1'b1;
        while (!stop && cyc < BUDGET) begin
            @(negedge CLK);
            start0 = 1'b0;
            start1 = 1'b0;
            cyc++;
            if (xfer) ptr++;
            if (cyc == 1) begin
                hold_first = s ? hold1 : hold0;
                ve_first   = s ? verr1 : verr0;
            end
            if (restart && cyc == 3) begin
                num_words = 8'd9;
                if (s) start1 = 1'b1; else start0 = 1'b1;
            end
            if ((s ? done1 : done0) === 1'b1) begin
                cycles = cyc;
                stop = 1'b1;
            end else if (rst_at >= 0 && ptr == rst_at) begin
                RST = 1'b1;
                stop = 1'b1;
            end
            byte_valid = !stop && (gaps ? (cyc % 3 == 1) : 1'b1);
            byte_in = byte_at(mode, ptr);
            xfer = byte_valid && ((s ? lif1.byte_ready : lif0.byte_ready) === 1'b1);
        end
        byte_valid = 1'b0;
        check("load_ends", {63'b0, stop}, 64'd1);
    endtask

    initial begin
        int cyc;
        logic h;
        logic v;
        int w0;

        RST = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_outputs", outs0, 0);
        check("rst_bus_free", {63'b0, (mem_bus0 !== 32'hzzzz_zzzz && mem_bus0 !== 32'h0)}, 0);
        RST = 1'b0;
        repeat (10) @(negedge CLK);
        check("idle_outputs", outs0, 0);
        check("idle_no_cs", cs0, 0);

        // Basic two-word load, one byte per cycle; start held off bus until accepted.
        run_load(1'b0, 8'd2, 0, 1'b0, 1'b0, -1, cyc, h, v);
        check("basic_done_cycles", cyc, 2 * CPW + 1);
        check("basic_hold_rise", h, 1);
        check("basic_ram0", ram0[0], 32'h1234_5678);
        check("basic_ram1", ram0[1], 32'hABCD_EF01);
        check("basic_words", wl0, 2);
        check("basic_hold_done", hold0, 0);
        check("basic_writes", writes0, 2);
        check("basic_verify_err", verr0, 0);
        @(negedge CLK);
        check("done_one_cycle", {done0, busy0}, 0);

        // Gapped valid (1,0,0,...) plus a start pulse while busy that must be ignored.
        w0 = writes0;
        run_load(1'b0, 8'd2, 1, 1'b1, 1'b1, -1, cyc, h, v);
        check("gap_ram0", ram0[0], 32'h0001_0203);
        check("gap_ram1", ram0[1], 32'h0405_0607);
        check("gap_words", wl0, 2);
        check("gap_writes", writes0 - w0, 2);

        // Zero-length load: immediate done, no Memory access, CPU never held.
        w0 = cs0;
        run_load(1'b0, 8'd0, 0, 1'b0, 1'b0, -1, cyc, h, v);
        check("zero_done_cycles", cyc, 1);
        check("zero_hold", h, 0);
        check("zero_words", wl0, 0);
        @(negedge CLK);
        check("zero_no_cs", cs0 - w0, 0);

        // Clamp 200 -> 128 on the base-120 instance; addresses wrap 127 -> 0.
        run_load(1'b1, 8'd200, 1, 1'b0, 1'b0, -1, cyc, h, v);
        check("clamp_done_cycles", cyc, 128 * CPW + 1);
        check("clamp_words", wl1, 128);
        check("clamp_writes", writes1, 128);
        check("wrap_first", ram1[120], 32'h0001_0203);
        check("wrap_127", ram1[127], 32'h1C1D_1E1F);
        check("wrap_0", ram1[0], 32'h2021_2223);
        check("wrap_last", ram1[119], 32'hBCBD_BEBF);
        sel = 1'b1;
        byte_valid = 1'b1;
        repeat (5) @(negedge CLK);
        check("clamp_stays_idle", {lif1.byte_ready, busy1}, 0);
        check("clamp_no_extra", writes1, 128);
        byte_valid = 1'b0;
        sel = 1'b0;

        // Reset after the 2nd byte of word 1: word 0 kept, word 1 untouched, bus released.
        run_load(1'b0, 8'd3, 2, 1'b0, 1'b0, 6, cyc, h, v);
        @(negedge CLK);
        check("midrst_outputs", outs0, 0);
        check("midrst_bus_free", {63'b0, (mem_bus0 !== 32'hzzzz_zzzz && mem_bus0 !== 32'h0)}, 0);
        RST = 1'b0;
        check("midrst_ram0", ram0[0], 32'hC0C1_C2C3);
        check("midrst_ram1", ram0[1], 32'h0405_0607);
        run_load(1'b0, 8'd2, 2, 1'b0, 1'b0, -1, cyc, h, v);
        check("reload_done_cycles", cyc, 2 * CPW + 1);
        check("reload_ram1", ram0[1], 32'hC4C5_C6C7);
        check("reload_words", wl0, 2);

`ifdef LOADER_VERIFY_EN
        // Corrupted read-back of word 0: error latches, load completes, next start clears it.
        corrupt = 1'b1;
        run_load(1'b0, 8'd2, 0, 1'b0, 1'b0, -1, cyc, h, v);
        corrupt = 1'b0;
        check("verify_err_set", verr0, 1);
        check("verify_completes", wl0, 2);
        check("verify_done_cycles", cyc, 13);
        check("verify_ram0", ram0[0], 32'h1234_5678);
        run_load(1'b0, 8'd1, 0, 1'b0, 1'b0, -1, cyc, h, v);
        check("verify_err_clear", v, 0);
        check("verify_err_clean", verr0, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
